// File: rtl/uart_pkg.sv
// Shared UART definitions.
//  - parity and baud codes as they appear on the configuration inputs
//  - baud_div(): number of clocks between 16x oversampling ticks
//  - bit positions inside error_flag
//  - receiver state encoding, also exported for debug
package uart_pkg;

    localparam int OVERSMP = 16;
    localparam int DIV_W   = 16;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam int ERR_PARITY = 0;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic int baud_hz(input logic [1:0] code);
        int rate;
        rate = 19200;
        case (code)
            BAUD_2400:  rate = 2400;
            BAUD_4800:  rate = 4800;
            BAUD_9600:  rate = 9600;
            default:    rate = 19200;
        endcase
        return rate;
    endfunction

    // Truncating division: the tick period is never longer than the ideal one.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [1:0] code);
        return DIV_W'(clk_freq / (OVERSMP * baud_hz(code)));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator, shared by the RX and TX paths.
// Ports:
//   clock     in  system clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   en        in  run the divider; while low the count is held at 0
//   baud_rate in  baud code (see uart_pkg)
//   tick      out one-clock pulse every baud_div(CLK_FREQ, baud_rate) clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] baud_rate,
    output logic       tick
);

    localparam logic [DIV_W-1:0] DIV_2400  = baud_div(CLK_FREQ, BAUD_2400);
    localparam logic [DIV_W-1:0] DIV_4800  = baud_div(CLK_FREQ, BAUD_4800);
    localparam logic [DIV_W-1:0] DIV_9600  = baud_div(CLK_FREQ, BAUD_9600);
    localparam logic [DIV_W-1:0] DIV_19200 = baud_div(CLK_FREQ, BAUD_19200);

    logic [DIV_W-1:0] w_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    always_comb begin
        w_div = DIV_19200;
        case (baud_rate)
            BAUD_2400:  w_div = DIV_2400;
            BAUD_4800:  w_div = DIV_4800;
            BAUD_9600:  w_div = DIV_9600;
            default:    w_div = DIV_19200;
        endcase
    end

    assign w_wrap = (r_cnt == (w_div - DIV_W'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign tick = en && w_wrap;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// 16x oversampling with a single sample taken at the middle of each bit.
// Ports:
//   clock          in  system clock
//   reset_n        in  asynchronous active-low reset
//   rx_in          in  serial line (asynchronous, idles high)
//   parity_type    in  00 none, 01 odd, 10 even, 11 none (latched per frame)
//   baud_rate      in  00 2400, 01 4800, 10 9600, 11 19200 (latched per frame)
//   data_out       out last received byte
//   rx_active_flag out high while a frame is in progress
//   rx_done_flag   out one-clock strobe; data_out/error_flag are valid in that
//                      cycle and hold afterwards (no back-pressure exists, the
//                      consumer must take the strobe when it arrives)
//   error_flag     out [0] parity, [1] start, [2] stop error
//   o_dbg_state    out current receiver state
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OVERSMP  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       rx_active_flag,
    output logic       rx_done_flag,
    output logic [2:0] error_flag,
    output rx_state_e  o_dbg_state
);

    rx_state_e  r_state, w_next_state;
    logic       r_sync1, r_sync2, r_rx_prev;
    logic       w_rx_s, w_start_det, w_tick, w_sample, w_par_en;
    logic [1:0] r_baud, r_par;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift, r_data_out;
    logic       r_done;
    logic [2:0] r_err;

    assign w_rx_s = r_sync2;
    // Edge, not level: after a break (line stuck low) the line must return
    // high before another start can be recognised.
    assign w_start_det = r_rx_prev && !w_rx_s;
    assign w_par_en    = (r_par == PAR_ODD) || (r_par == PAR_EVEN);
    // Start bit is sampled 8 ticks in (its middle); every later bit 16 ticks on.
    assign w_sample = w_tick && ((r_state == RX_START) ? (r_tick_cnt == 4'd7)
                                                       : (r_tick_cnt == 4'd15));

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (r_state != RX_IDLE),
        .baud_rate (r_baud),
        .tick      (w_tick)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= RX_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE:   if (w_start_det) w_next_state = RX_START;
            RX_START:  if (w_sample) w_next_state = w_rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_sample && (r_bit_cnt == 3'd7))
                           w_next_state = w_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_sample) w_next_state = RX_STOP;
            RX_STOP:   if (w_sample) w_next_state = RX_IDLE;
            default:   w_next_state = RX_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        rx_active_flag = (r_state != RX_IDLE);
        o_dbg_state    = r_state;
    end

    assign data_out     = r_data_out;
    assign rx_done_flag = r_done;
    assign error_flag   = r_err;

    // Synchroniser, counters, shift register and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_baud     <= '0;
            r_par      <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_err      <= '0;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx_s;
            r_done    <= 1'b0;
            if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
            case (r_state)
                RX_IDLE: begin
                    if (w_start_det) begin
                        r_err      <= '0;
                        r_baud     <= baud_rate;
                        r_par      <= parity_type;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (w_sample) begin
                        r_tick_cnt <= '0;
                        if (w_rx_s) begin
                            r_err[ERR_START] <= 1'b1;
                            r_done           <= 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                RX_PARITY: begin
                    if (w_sample) begin
                        if ((r_par == PAR_EVEN) ? ((^r_shift) != w_rx_s)
                                                : ((~^r_shift) != w_rx_s))
                            r_err[ERR_PARITY] <= 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_sample) begin
                        if (!w_rx_s) r_err[ERR_STOP] <= 1'b1;
                        r_data_out <= r_shift;
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_536_000;
    localparam int TOL      = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_out;
    logic       rx_active_flag;
    logic       rx_done_flag;
    logic [2:0] error_flag;
    rx_state_e  dbg_state;

    uart_rx_core #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx_in          (rx_in),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .data_out       (data_out),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag),
        .error_flag     (error_flag),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // entry = {updates_data, data[7:0], err[2:0]}
    logic [11:0] exp_q[$];
    int          exp_t_q[$];
    logic [7:0]  exp_data = 8'h00;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bit_clks(input logic [1:0] b);
        int rate;
        case (b)
            2'b00:   rate = 2400;
            2'b01:   rate = 4800;
            2'b10:   rate = 9600;
            default: rate = 19200;
        endcase
        return 16 * (CLK_FREQ / (16 * rate));
    endfunction

    always @(negedge clock) begin
        if (reset_n && chk_en) begin
            if (exp_q.size() > 0 && cyc > exp_t_q[0] + TOL) begin
                chk("done_timeout", 0, 1);
                void'(exp_q.pop_front());
                void'(exp_t_q.pop_front());
            end
            if (rx_done_flag) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    logic [11:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    n_chk++;
                    if (cyc < t - TOL || cyc > t + TOL) begin
                        n_fail++;
                        $display("FAIL done_cycle: got %0d expected %0d +/- %0d", cyc, t, TOL);
                    end
                    if (e[11]) exp_data = e[10:3];
                    chk("error_flag", int'(error_flag), int'(e[2:0]));
                    chk("active_at_done", int'(rx_active_flag), 0);
                end
            end
            chk("data_out", int'(data_out), int'(exp_data));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] par,
                               input bit flip_par, input bit stop_val, input bit scramble,
                               input bit use_lit, input logic [2:0] lit_err);
        int bc, nb, t0;
        bit par_en, p;
        logic [2:0] err;
        bc = bit_clks(b);
        par_en = (par == 2'b01) || (par == 2'b10);
        p = ((par == 2'b01) ? ~(^d) : (^d)) ^ flip_par;
        err = 3'b000;
        if (par == 2'b10 && (^d) != p) err[0] = 1'b1;
        if (par == 2'b01 && (~(^d)) != p) err[0] = 1'b1;
        if (!stop_val) err[2] = 1'b1;
        if (use_lit) err = lit_err;
        nb = par_en ? 11 : 10;
        baud_rate = b;
        parity_type = par;
        rx_in = 1'b0;
        t0 = cyc;
        exp_q.push_back({1'b1, d, err});
        exp_t_q.push_back(t0 + bc * (nb - 1) + bc / 2 + 3);
        wait_clks(bc / 8);
        if (scramble) begin
            baud_rate = 2'($urandom_range(0, 3));
            parity_type = 2'($urandom_range(0, 3));
        end
        wait_clks(bc - bc / 8);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_clks(bc);
            if (i == 2) begin
                chk("mid_err_clear", int'(error_flag), 0);
                chk("mid_active", int'(rx_active_flag), 1);
            end
        end
        if (par_en) begin
            rx_in = p;
            wait_clks(bc);
        end
        rx_in = stop_val;
        wait_clks(bc);
    endtask

    task automatic glitch(input logic [1:0] b, input int width);
        int bc;
        bc = bit_clks(b);
        baud_rate = b;
        rx_in = 1'b0;
        exp_q.push_back({1'b0, 8'h00, 3'b010});
        exp_t_q.push_back(cyc + bc / 2 + 3);
        wait_clks(width);
        rx_in = 1'b1;
        wait_clks(bc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        rx_in = 1'b1;
        baud_rate = 2'b10;
        parity_type = 2'b00;
        wait_clks(3);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_done", int'(rx_done_flag), 0);
        chk("rst_active", int'(rx_active_flag), 0);
        chk("rst_error", int'(error_flag), 0);
        reset_n = 1'b1;
        wait_clks(2);
        chk_en = 1'b1;

        // 1: plain frame, no parity
        drive_frame(8'hA5, 2'b10, 2'b00, 0, 1, 0, 1, 3'b000);
        wait_clks(160);
        // 2: even parity, good then bad parity bit
        drive_frame(8'h3C, 2'b11, 2'b10, 0, 1, 0, 1, 3'b000);
        wait_clks(80);
        drive_frame(8'h3C, 2'b11, 2'b10, 1, 1, 0, 1, 3'b001);
        wait_clks(80);
        // 3: quarter-bit glitch is a false start, then a clean frame
        glitch(2'b10, 40);
        drive_frame(8'h5A, 2'b10, 2'b00, 0, 1, 0, 1, 3'b000);
        wait_clks(160);
        // 4: odd parity, stop bit low, line held low (break)
        drive_frame(8'h00, 2'b10, 2'b01, 0, 0, 0, 1, 3'b100);
        wait_clks(320);
        chk("break_no_frame", int'(rx_active_flag), 0);
        rx_in = 1'b1;
        wait_clks(160);
        // 5: back-to-back frames with no idle gap
        drive_frame(8'h12, 2'b00, 2'b00, 0, 1, 0, 1, 3'b000);
        drive_frame(8'h34, 2'b00, 2'b00, 0, 1, 0, 1, 3'b000);
        wait_clks(640);
        // 6: asynchronous reset in the middle of the data bits
        baud_rate = 2'b01;
        parity_type = 2'b00;
        rx_in = 1'b0;
        wait_clks(320);
        for (int i = 0; i < 3; i++) begin
            rx_in = i[0];
            wait_clks(320);
        end
        wait_clks(160);
        chk("active_mid_data", int'(rx_active_flag), 1);
        #2;
        reset_n = 1'b0;
        rx_in = 1'b1;
        exp_q.delete();
        exp_t_q.delete();
        exp_data = 8'h00;
        #1;
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_done", int'(rx_done_flag), 0);
        chk("async_rst_active", int'(rx_active_flag), 0);
        chk("async_rst_error", int'(error_flag), 0);
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(320);
        drive_frame(8'hFF, 2'b01, 2'b00, 0, 1, 0, 1, 3'b000);
        wait_clks(320);

        // randomized frames; config inputs are scrambled mid-frame
        for (int n = 0; n < 10; n++) begin
            logic [1:0] b;
            int bc;
            b = 2'($urandom_range(1, 3));
            bc = bit_clks(b);
            drive_frame(8'($urandom_range(0, 255)), b, 2'($urandom_range(0, 3)),
                        bit'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0), 1, 0, 3'b000);
            rx_in = 1'b1;
            wait_clks($urandom_range(bc / 2, 2 * bc));
        end

        for (int k = 0; k < 2000 && exp_q.size() > 0; k++) wait_clks(1);
        chk("pending_frames", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clock);
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus expected completion within 95000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
